// File: rtl/stopwatch_pkg.sv
// Shared timer definitions: state encodings, BCD digit limits, blank code and tick-rate constants.
// Used by the stopwatch and by any other block that counts H:MM:SS in BCD.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STOP = 3'd2,
    ST_LAP  = 3'd3,
    ST_OVF  = 3'd4
  } sw_state_t;

  localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX_5 = 4'd5;
  localparam logic [3:0] BLANK_CODE  = 4'hA;

  localparam int unsigned CLK_FREQ_HZ  = 50_000_000;
  localparam int unsigned TICK_FREQ_HZ = 1;
  localparam int unsigned TICK_DIVIDE  = CLK_FREQ_HZ / TICK_FREQ_HZ;

  typedef struct packed {
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } hms_t;

  localparam hms_t HMS_ZERO = '0;

endpackage

// File: rtl/bcd_hms_incr.sv
// Combinational H:MM:SS BCD incrementer with saturation flag.
// At MAX_H0:59:59 the count is held and at_max is raised instead of wrapping.
module bcd_hms_incr
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX_H0 = 4'd9
) (
  input  hms_t cur,
  output hms_t nxt,
  output logic at_max
);

  always_comb begin
    nxt    = cur;
    at_max = (cur.h0 == MAX_H0) && (cur.m1 == DIGIT_MAX_5) && (cur.m0 == DIGIT_MAX_9) &&
             (cur.s1 == DIGIT_MAX_5) && (cur.s0 == DIGIT_MAX_9);
    if (!at_max) begin
      if (cur.s0 != DIGIT_MAX_9) begin
        nxt.s0 = cur.s0 + 4'd1;
      end else begin
        nxt.s0 = 4'd0;
        if (cur.s1 != DIGIT_MAX_5) begin
          nxt.s1 = cur.s1 + 4'd1;
        end else begin
          nxt.s1 = 4'd0;
          if (cur.m0 != DIGIT_MAX_9) begin
            nxt.m0 = cur.m0 + 4'd1;
          end else begin
            nxt.m0 = 4'd0;
            if (cur.m1 != DIGIT_MAX_5) begin
              nxt.m1 = cur.m1 + 4'd1;
            end else begin
              nxt.m1 = 4'd0;
              nxt.h0 = cur.h0 + 4'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch.sv
// Stopwatch with start/stop, lap freeze and overflow hold; H0:M1M0:S1S0 BCD display,
// digits registered one cycle behind the live count (or the lap register while in LAP).
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX_H0 = 4'd9
) (
  input  logic       CLK_50,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       toggle,
  input  logic       lap,
  input  logic       clear,
  output logic       running,
  output logic       lap_shown,
  output logic       overflow,
  output logic [3:0] H1,
  output logic [3:0] H0,
  output logic [3:0] M1,
  output logic [3:0] M0,
  output logic [3:0] S1,
  output logic [3:0] S0
);

  sw_state_t state_reg, state_next;
  hms_t      count_reg, count_next;
  hms_t      lap_reg, lap_next;
  hms_t      disp_reg, disp_next;
  hms_t      incr_value;
  logic      incr_at_max;
  logic      count_en;

  bcd_hms_incr #(.MAX_H0(MAX_H0)) u_incr (
    .cur    (count_reg),
    .nxt    (incr_value),
    .at_max (incr_at_max)
  );

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      count_reg <= HMS_ZERO;
      lap_reg   <= HMS_ZERO;
      disp_reg  <= HMS_ZERO;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      lap_reg   <= lap_next;
      disp_reg  <= disp_next;
    end
  end

  assign count_en = tick_1hz && ((state_reg == ST_RUN) || (state_reg == ST_LAP));

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    lap_next   = lap_reg;
    disp_next  = (state_reg == ST_LAP) ? lap_reg : count_reg;
    if (count_en && !incr_at_max) begin
      count_next = incr_value;
    end
    if (clear) begin
      state_next = ST_IDLE;
      count_next = HMS_ZERO;
      lap_next   = HMS_ZERO;
    end else if (count_en && incr_at_max) begin
      // Saturation outranks toggle/lap: the held count must not be left running.
      state_next = ST_OVF;
    end else begin
      unique case (state_reg)
        ST_IDLE: if (toggle) state_next = ST_RUN;
        ST_RUN: begin
          if (toggle) begin
            state_next = ST_STOP;
          end else if (lap) begin
            state_next = ST_LAP;
            lap_next   = count_next;
          end
        end
        ST_LAP: begin
          if (toggle)   state_next = ST_STOP;
          else if (lap) state_next = ST_RUN;
        end
        ST_STOP: begin
          if (toggle) begin
            state_next = ST_RUN;
          end else if (lap) begin
            state_next = ST_IDLE;
            count_next = HMS_ZERO;
          end
        end
        ST_OVF:  state_next = ST_OVF;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign running   = (state_reg == ST_RUN) || (state_reg == ST_LAP);
  assign lap_shown = (state_reg == ST_LAP);
  assign overflow  = (state_reg == ST_OVF);

  assign H1 = BLANK_CODE;
  assign H0 = disp_reg.h0;
  assign M1 = disp_reg.m1;
  assign M0 = disp_reg.m0;
  assign S1 = disp_reg.s1;
  assign S0 = disp_reg.s0;

endmodule

// File: doc/stopwatch.md
STOPWATCH -- requirements
Module: stopwatch

Interface
REQ-001 SHALL have parameter MAX_H0, default 4'd9, upper limit of the hours digit.
REQ-002 SHALL have port CLK_50  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port tick_1hz  input  1  one-CLK_50-cycle pulse, once per second.
REQ-005 SHALL have port toggle  input  1  one-cycle pulse, start/stop.
REQ-006 SHALL have port lap  input  1  one-cycle pulse, lap freeze/release, or zero when stopped.
REQ-007 SHALL have port clear  input  1  one-cycle pulse, unconditional return to idle.
REQ-008 SHALL have port running  output  1  high in RUN or LAP.
REQ-009 SHALL have port lap_shown  output  1  high in LAP.
REQ-010 SHALL have port overflow  output  1  high in OVF.
REQ-011 SHALL have port H1  output  4  constant 4'hA, blank code.
REQ-012 SHALL have ports H0, M1, M0, S1, S0  output  4 each  registered BCD display digits.

Function
REQ-013 SHALL implement states IDLE, RUN, STOP, LAP and OVF.
REQ-014 Input priority SHALL be clear > toggle > lap.
REQ-015 clear SHALL move any state to IDLE and zero both the live count and the lap register.
REQ-016 Transitions SHALL be:
- IDLE: toggle -> RUN.
- RUN: toggle -> STOP; lap -> LAP.
- LAP: lap -> RUN; toggle -> STOP.
- STOP: toggle -> RUN; lap -> IDLE, with the count zeroed.
- OVF: only clear leaves OVF.
- Unlisted inputs are ignored.
REQ-017 The live count SHALL increment only on cycles where tick_1hz=1 and the current state is RUN or LAP, using the state before that edge.
REQ-018 When a tick coincides with toggle in RUN, the tick SHALL be counted and the state SHALL go to STOP.
REQ-019 When a tick coincides with toggle in STOP, the tick SHALL be ignored.
REQ-020 Increment SHALL be BCD ripple-carry:
- S0 9->0 carries into S1.
- S1 5->0 carries into M0.
- M0 9->0 carries into M1.
- M1 5->0 carries into H0.
REQ-021 A tick at count MAX_H0:59:59 SHALL hold the count and enter OVF on the same edge.
REQ-022 The count SHALL never wrap to zero.
REQ-023 Entering LAP SHALL capture the live count (including any same-edge increment) into the lap register.
REQ-024 Counting SHALL continue during LAP.
REQ-025 The digit outputs SHALL show the lap register in LAP and the live count in every other state.
REQ-026 The digit outputs SHALL lag the selected source by exactly one CLK_50 cycle.
REQ-027 running, lap_shown and overflow SHALL decode directly from the state register with zero lag.
REQ-028 No digit SHALL ever hold a non-BCD value or exceed its maximum (S1, M1 <= 5; H0 <= MAX_H0).

Reset
REQ-029 On reset_n low the block SHALL asynchronously enter IDLE and zero the live count, the lap register and the digit outputs (H1 remains 4'hA).
REQ-030 Deassertion of reset_n SHALL be synchronous; the first active edge accepts inputs normally.
REQ-031 Reset mid-count or in OVF SHALL discard all state with no residual carry.

Structure
REQ-032 The shared timer package SHALL hold:
- state encodings (3-bit);
- digit maxima 4'd9 and 4'd5;
- blank code 4'hA;
- tick-rate constants.
REQ-033 A sub-module bcd_hms_incr SHALL compute next-count and an at_max flag combinationally; it is reusable by the countdown timer.
REQ-034 The top level SHALL hold the FSM, the count, lap and output registers, and the mux.

Verification
REQ-035 Reset, toggle, 75 ticks, toggle SHALL give 0:01:15 and STOP, with the digits updating one cycle after each tick.
REQ-036 Starting at 0:00:59, one tick SHALL give 0:01:00.
REQ-037 Starting at 0:59:59, one tick SHALL give 1:00:00.
REQ-038 Lap at 0:00:10 then 5 ticks SHALL show 0:00:10 with lap_shown=1; a second lap SHALL then show 0:00:15.
REQ-039 Starting at 9:59:59 in RUN, one tick SHALL hold 9:59:59 with overflow=1; toggle and lap SHALL then be ignored, and clear SHALL give 0:00:00 in IDLE.
REQ-040 Tick with toggle in the same cycle from RUN at 0:00:03 SHALL give 0:00:04 in STOP; lap in STOP SHALL then give 0:00:00 in IDLE.
REQ-041 Asserting reset_n low mid-RUN at 0:12:34, off-edge, SHALL zero the outputs immediately; clear together with toggle SHALL give IDLE.
